irq_arbiter: RTL and testbench

- Sits directly downstream of the APB event/interrupt unit.
- Consumes its 32-bit level interrupt vector (pending & mask) and selects one line. Presents that line to the core as a registered request plus a 5-bit ID.
- Runs the core's ack handshake and reports the acknowledged line back as a one-hot pulse.
- Masks the acknowledged line for a bounded hold window, so a not-yet-cleared pending bit does not re-trigger the core immediately.

---
 rtl/irq_arbiter_if.sv | 22 ++
 rtl/irq_arbiter.sv | 149 ++++++++++++++
 tb/tb_irq_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// Core-side interrupt handshake: registered request/ID out, single-cycle ack/ID back.
// The slave modport is the arbiter's view; the master modport is the core's view.
interface irq_arbiter_if;
  logic       core_irq_o;
  logic [4:0] core_irq_id_o;
  logic       core_irq_ack_i;
  logic [4:0] core_irq_ack_id_i;

  modport slave (
    output core_irq_o,
    output core_irq_id_o,
    input  core_irq_ack_i,
    input  core_irq_ack_id_i
  );

  modport master (
    input  core_irq_o,
    input  core_irq_id_o,
    output core_irq_ack_i,
    output core_irq_ack_id_i
  );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: picks one pending line (fixed or rotating priority), requests the core,
// runs the ack handshake and masks the acked line for a bounded hold window. Outputs are registered.
module irq_arbiter #(
  parameter int NUM_IRQ     = 32,
  parameter int RR_EN       = 0,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_IRQ-1:0] irq_i,
  irq_arbiter_if.slave       core_if,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               ack_err_o,
  output logic               hold_active_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         id_q, id_d;
  logic [4:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;

  logic [NUM_IRQ-1:0]   id_onehot;
  logic [NUM_IRQ-1:0]   eff;
  logic [2*NUM_IRQ-1:0] eff_dbl;
  logic [2*NUM_IRQ-1:0] eff_rot;
  logic                 irq_held;
  logic                 sel_vld;
  logic [4:0]           sel_id;
  logic [4:0]           rot_off;
  logic [5:0]           rot_sum;
  logic                 ack_match;

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_onehot[i] = (id_q == 5'(i));
    end
  end

  assign irq_held = |(irq_i & id_onehot);
  assign eff      = (state_q == HOLD) ? (irq_i & ~id_onehot) : irq_i;

  // Rotating scan: shift a doubled copy down by rr_ptr so the lowest set bit is the winner.
  assign eff_dbl = {eff, eff};
  assign eff_rot = eff_dbl >> rr_ptr_q;

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    rot_off = '0;
    rot_sum = '0;
    if (RR_EN == 0) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (eff[i]) begin
          sel_vld = 1'b1;
          sel_id  = 5'(i);
        end
      end
    end else begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (eff_rot[i]) begin
          sel_vld = 1'b1;
          rot_off = 5'(i);
        end
      end
      rot_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
      if (rot_sum >= 6'(NUM_IRQ)) begin
        rot_sum = rot_sum - 6'(NUM_IRQ);
      end
      sel_id = rot_sum[4:0];
    end
  end

  // Out-of-range IDs can never equal id_q, but the explicit guard keeps intent obvious.
  assign ack_match = core_if.core_irq_ack_i && (state_q == REQ) &&
                     (core_if.core_irq_ack_id_i == id_q) &&
                     ({1'b0, core_if.core_irq_ack_id_i} < 6'(NUM_IRQ));

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    err_d    = core_if.core_irq_ack_i && !ack_match;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = REQ;
          id_d    = sel_id;
        end
      end
      REQ: begin
        if (ack_match) begin
          state_d  = HOLD;
          cnt_d    = 8'(HOLD_CYCLES - 1);
          ack_d    = id_onehot;
          rr_ptr_d = (id_q == 5'(NUM_IRQ - 1)) ? 5'd0 : id_q + 5'd1;
        end else if (!irq_held) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if ((cnt_q == 8'd0) || !irq_held) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      id_q     <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign core_if.core_irq_o    = (state_q == REQ);
  assign core_if.core_irq_id_o = id_q;
  assign irq_ack_o             = ack_q;
  assign ack_err_o             = err_q;
  assign hold_active_o         = (state_q == HOLD);

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench: cycle table on a fixed-priority instance, hand sequences for rotating grants and reset.
module tb_irq_arbiter;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESETn;
  logic [31:0] irq_fp, irq_rr;
  logic [31:0] ack_fp, ack_rr;
  logic        err_fp, err_rr, hold_fp, hold_rr;

  irq_arbiter_if if_fp ();
  irq_arbiter_if if_rr ();

  irq_arbiter #(.NUM_IRQ(32), .RR_EN(0), .HOLD_CYCLES(8)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .irq_i(irq_fp), .core_if(if_fp),
    .irq_ack_o(ack_fp), .ack_err_o(err_fp), .hold_active_o(hold_fp)
  );

  irq_arbiter #(.NUM_IRQ(32), .RR_EN(1), .HOLD_CYCLES(8)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .irq_i(irq_rr), .core_if(if_rr),
    .irq_ack_o(ack_rr), .ack_err_o(err_rr), .hold_active_o(hold_rr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] irq;
    logic        ack;
    logic [4:0]  ack_id;
    logic        e_core;
    logic [4:0]  e_id;
    logic [31:0] e_ack;
    logic        e_err;
    logic        e_hold;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(logic [31:0] irq, logic ack, logic [4:0] aid, logic c,
                              logic [4:0] id, logic [31:0] a, logic e, logic h);
    vec_t r;
    r.irq = irq; r.ack = ack; r.ack_id = aid;
    r.e_core = c; r.e_id = id; r.e_ack = a; r.e_err = e; r.e_hold = h;
    return r;
  endfunction

  // Waits for a rotating-mode request, checks its ID and optionally acks it.
  task automatic rr_grant(input logic [4:0] exp_id, input bit do_ack, input string nm);
    int n;
    n = 0;
    while (!if_rr.core_irq_o && n < 40) begin
      @(negedge HCLK);
      n++;
    end
    check({nm, "_req"}, {31'd0, if_rr.core_irq_o}, 32'd1);
    check({nm, "_id"}, {27'd0, if_rr.core_irq_id_o}, {27'd0, exp_id});
    if (do_ack) begin
      @(posedge HCLK); #1;
      if_rr.core_irq_ack_i    = 1'b1;
      if_rr.core_irq_ack_id_i = exp_id;
      @(posedge HCLK); #1;
      if_rr.core_irq_ack_i    = 1'b0;
      @(negedge HCLK);
      check({nm, "_ackpulse"}, ack_rr, 32'd1 << exp_id);
      check({nm, "_hold"}, {31'd0, hold_rr}, 32'd1);
      check({nm, "_reqdrop"}, {31'd0, if_rr.core_irq_o}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // irq, ack, ack_id | core, id, irq_ack, err, hold (outputs seen in that cycle)
    tbl[0]  = mk(32'h14, 0, 0, 0, 0, 32'h0,  0, 0);
    tbl[1]  = mk(32'h14, 0, 0, 1, 4, 32'h0,  0, 0);
    tbl[2]  = mk(32'h14, 0, 0, 1, 4, 32'h0,  0, 0);
    tbl[3]  = mk(32'h14, 1, 4, 1, 4, 32'h0,  0, 0);
    tbl[4]  = mk(32'h14, 0, 0, 0, 4, 32'h10, 0, 1);
    for (int i = 5; i <= 11; i++) tbl[i] = mk(32'h14, 0, 0, 0, 4, 32'h0, 0, 1);
    tbl[12] = mk(32'h14, 0, 0, 0, 4, 32'h0,  0, 0);
    tbl[13] = mk(32'h14, 0, 0, 1, 4, 32'h0,  0, 0);
    tbl[14] = mk(32'h14, 1, 4, 1, 4, 32'h0,  0, 0);
    tbl[15] = mk(32'h14, 0, 0, 0, 4, 32'h10, 0, 1);
    tbl[16] = mk(32'h14, 0, 0, 0, 4, 32'h0,  0, 1);
    tbl[17] = mk(32'h04, 0, 0, 0, 4, 32'h0,  0, 1);
    tbl[18] = mk(32'h04, 0, 0, 0, 4, 32'h0,  0, 0);
    tbl[19] = mk(32'h04, 1, 6, 1, 2, 32'h0,  0, 0);
    tbl[20] = mk(32'h00, 0, 0, 1, 2, 32'h0,  1, 0);
    tbl[21] = mk(32'h20, 0, 0, 0, 2, 32'h0,  0, 0);
    tbl[22] = mk(32'h20, 1, 6, 1, 5, 32'h0,  0, 0);
    tbl[23] = mk(32'h00, 1, 5, 1, 5, 32'h0,  1, 0);
    tbl[24] = mk(32'h00, 0, 0, 0, 5, 32'h20, 0, 1);
    tbl[25] = mk(32'h00, 1, 3, 0, 5, 32'h0,  0, 0);
    tbl[26] = mk(32'h01, 0, 0, 0, 5, 32'h0,  1, 0);
    tbl[27] = mk(32'h00, 0, 0, 1, 0, 32'h0,  0, 0);
    tbl[28] = mk(32'h01, 0, 0, 0, 0, 32'h0,  0, 0);
    tbl[29] = mk(32'h00, 1, 0, 1, 0, 32'h0,  0, 0);
    tbl[30] = mk(32'h00, 0, 0, 0, 0, 32'h1,  0, 1);
    tbl[31] = mk(32'h00, 0, 0, 0, 0, 32'h0,  0, 0);

    HRESETn = 1'b0;
    irq_fp = '0;
    irq_rr = '0;
    if_fp.core_irq_ack_i = 1'b0;  if_fp.core_irq_ack_id_i = '0;
    if_rr.core_irq_ack_i = 1'b0;  if_rr.core_irq_ack_id_i = '0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    for (int i = 0; i < 32; i++) begin
      irq_fp = tbl[i].irq;
      if_fp.core_irq_ack_i    = tbl[i].ack;
      if_fp.core_irq_ack_id_i = tbl[i].ack_id;
      @(negedge HCLK);
      check($sformatf("row%0d core_irq", i), {31'd0, if_fp.core_irq_o}, {31'd0, tbl[i].e_core});
      check($sformatf("row%0d id", i), {27'd0, if_fp.core_irq_id_o}, {27'd0, tbl[i].e_id});
      check($sformatf("row%0d irq_ack", i), ack_fp, tbl[i].e_ack);
      check($sformatf("row%0d ack_err", i), {31'd0, err_fp}, {31'd0, tbl[i].e_err});
      check($sformatf("row%0d hold", i), {31'd0, hold_fp}, {31'd0, tbl[i].e_hold});
      @(posedge HCLK); #1;
    end
    irq_fp = '0;
    if_fp.core_irq_ack_i = 1'b0;

    // Rotating grants 0,1,31,0 then a request for 1 is reset away.
    irq_rr = 32'h8000_0003;
    @(negedge HCLK);
    rr_grant(5'd0,  1'b1, "rr_g0");
    rr_grant(5'd1,  1'b1, "rr_g1");
    rr_grant(5'd31, 1'b1, "rr_g2");
    rr_grant(5'd0,  1'b1, "rr_g3");
    rr_grant(5'd1,  1'b0, "rr_g4");

    HRESETn = 1'b0;
    #1;
    check("rst_core_irq", {31'd0, if_rr.core_irq_o}, 32'd0);
    check("rst_id", {27'd0, if_rr.core_irq_id_o}, 32'd0);
    check("rst_hold", {31'd0, hold_rr}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rel_cycle0_core_irq", {31'd0, if_rr.core_irq_o}, 32'd0);
    @(negedge HCLK);
    check("rel_cycle1_core_irq", {31'd0, if_rr.core_irq_o}, 32'd1);
    check("rel_cycle1_id_rrptr0", {27'd0, if_rr.core_irq_id_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
